// File: rtl/btn_rt_pkg.sv
// Shared types and default timing constants for the long-press reset button detector.
package btn_rt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDING = 2'd1,
    FIRED   = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_HOLD_CYCLES     = 20000;
  localparam int DEF_CNT_W           = 15;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter that only lets the
// debounced level follow the synced input after DEBOUNCE_CYCLES of agreement.
module btn_debounce
  import btn_rt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db_level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] db_cnt;

  // Any sample agreeing with the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= 2'b00;
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_rt.sv
// Long-press detector: debounced button held for HOLD_CYCLES produces one
// registered single-cycle pulse per press.
module btn_rt
  import btn_rt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_in,
  output logic boton_out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             db_level;
  logic [CNT_W-1:0] hold_cnt;
  logic             fire;
  state_t           state;
  state_t           next_state;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (boton_in),
    .db_level (db_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (db_level) next_state = HOLDING;
      end
      HOLDING: begin
        if (!db_level)                 next_state = IDLE;
        else if (hold_cnt == HOLD_LAST) next_state = FIRED;
      end
      FIRED: begin
        if (!db_level) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fire = (state == HOLDING) && db_level && (hold_cnt == HOLD_LAST);
  end

  // Counter only runs while a valid hold is in progress; anything else parks it at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == HOLDING && db_level) begin
      if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boton_out <= 1'b0;
    end else begin
      boton_out <= fire;
    end
  end

endmodule

// File: tb/tb_btn_rt.sv
// Directed bench for btn_rt with shortened debounce/hold windows so every
// scenario finishes in a few thousand cycles.
module tb_btn_rt;

  localparam int DB   = 10;
  localparam int HOLD = 50;
  localparam int LAT  = 2 + DB + HOLD;

  logic clk;
  logic rst_n;
  logic boton_in;
  logic boton_out;

  int n_checks;
  int n_fail;
  int double_high;
  bit prev_out;

  btn_rt #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .CNT_W           (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .boton_in  (boton_in),
    .boton_out (boton_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Catch any pulse longer than one cycle across the whole run.
  always @(negedge clk) begin
    if (boton_out === 1'b1 && prev_out) double_high++;
    prev_out = (boton_out === 1'b1);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Holds boton_in at one level for a number of cycles; reports the first
  // pulse index (edge count from the first edge sampling the new level) and pulse count.
  task automatic applyStimulus(input logic btn, input int cycles,
                               output int first_pulse, output int pulses);
    first_pulse = -1;
    pulses      = 0;
    boton_in    = btn;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (boton_out === 1'b1) begin
        if (pulses == 0) first_pulse = n;
        pulses++;
      end
    end
  endtask

  initial begin
    int fp;
    int np;
    int total;

    n_checks    = 0;
    n_fail      = 0;
    double_high = 0;
    prev_out    = 1'b0;
    rst_n       = 1'b0;
    boton_in    = 1'b1;

    // Reset held with the button pressed
    applyStimulus(1'b1, 5, fp, np);
    checkOutput("reset_out", int'(boton_out), 0);
    checkOutput("reset_no_pulse", np, 0);

    rst_n = 1'b1;
    applyStimulus(1'b1, 100, fp, np);
    checkOutput("post_reset_latency", fp, LAT);
    checkOutput("post_reset_pulses", np, 1);

    applyStimulus(1'b0, 30, fp, np);
    checkOutput("release_no_pulse", np, 0);

    // Long press
    applyStimulus(1'b1, 150, fp, np);
    checkOutput("long_latency", fp, LAT);
    checkOutput("long_pulses", np, 1);
    applyStimulus(1'b0, 30, fp, np);

    // Short press
    total = 0;
    applyStimulus(1'b0, 100, fp, np); total += np;
    applyStimulus(1'b1, 30, fp, np);  total += np;
    applyStimulus(1'b0, 80, fp, np);  total += np;
    checkOutput("short_press_pulses", total, 0);

    // Glitch train shorter than the debounce window
    total = 0;
    for (int g = 0; g < 20; g++) begin
      applyStimulus(1'b1, DB / 2, fp, np); total += np;
      applyStimulus(1'b0, DB / 2, fp, np); total += np;
    end
    applyStimulus(1'b0, 80, fp, np); total += np;
    checkOutput("glitch_pulses", total, 0);

    applyStimulus(1'b1, 100, fp, np);
    checkOutput("after_glitch_latency", fp, LAT);
    applyStimulus(1'b0, 30, fp, np);

    // Hold through, brief release ignored, then a genuine re-press
    applyStimulus(1'b1, 300, fp, np);
    checkOutput("hold_through_latency", fp, LAT);
    checkOutput("hold_through_pulses", np, 1);
    total = 0;
    applyStimulus(1'b0, DB / 2, fp, np); total += np;
    applyStimulus(1'b1, 150, fp, np);    total += np;
    checkOutput("short_release_ignored", total, 0);
    applyStimulus(1'b0, DB + DB / 2, fp, np);
    checkOutput("long_release_no_pulse", np, 0);
    applyStimulus(1'b1, 150, fp, np);
    checkOutput("repress_latency", fp, LAT);
    checkOutput("repress_pulses", np, 1);
    applyStimulus(1'b0, 30, fp, np);

    // Reset mid-hold aborts the press
    applyStimulus(1'b1, 40, fp, np);
    checkOutput("mid_hold_no_pulse", np, 0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1, fp, np);
    checkOutput("mid_hold_reset_out", int'(boton_out), 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 120, fp, np);
    checkOutput("mid_hold_restart_latency", fp, LAT);
    checkOutput("mid_hold_restart_pulses", np, 1);

    checkOutput("pulse_width_single", double_high, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
